// File: rtl/health_calc_unit.sv
// Multi-cycle BMI / BMR / TDEE unit with valid/ready handshakes.
// A single request is in flight; divisions share one iterative restoring divider.
module health_calc_unit #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] height,
  input  logic [DATA_W-1:0] weight,
  input  logic [5:0]        age,
  input  logic              gender,
  input  logic [2:0]        activity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam int W2 = 2 * DATA_W;
  localparam int W3 = 3 * DATA_W;
  localparam int BW = DATA_W + 8;
  localparam int CW = $clog2(DATA_W) + 1;

  localparam logic [1:0] OP_BMI  = 2'b00;
  localparam logic [1:0] OP_BMR  = 2'b01;
  localparam logic [1:0] OP_TDEE = 2'b10;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t r_state, w_nextState;

  logic              r_readyEn;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_height, r_weight;
  logic [5:0]        r_age;
  logic              r_gender;
  logic [2:0]        r_activity;

  logic              r_err, r_sat;
  logic [W2-1:0]     r_rem;
  logic [W3-1:0]     r_dvs;
  logic [DATA_W-1:0] r_quot;
  logic [CW-1:0]     r_cnt;

  logic              r_outValid, r_errOut;
  logic [DATA_W-1:0] r_result;

  logic              w_err, w_divOp, w_ovf, w_ge;
  logic [BW-1:0]     w_bmr;
  logic [DATA_W-1:0] w_bmrClamped;
  logic [10:0]       w_factor;
  logic [W2-1:0]     w_dividend, w_divisor;

  assign in_ready  = (r_state == IDLE) && r_readyEn;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign err       = r_errOut;

  assign w_err = (r_op == 2'b11) ||
                 ((r_op == OP_BMI) && (r_height == '0)) ||
                 ((r_op == OP_TDEE) && (r_activity > 3'd4));
  assign w_divOp = (r_op == OP_BMI) || (r_op == OP_TDEE);

  // Two's-complement sum in BW bits; the positive terms cannot reach the sign bit.
  assign w_bmr = BW'(r_weight) * BW'(10)
               + ((BW'(r_height) * BW'(25)) >> 2)
               - BW'(r_age) * BW'(5)
               + (r_gender ? BW'(5) : BW'(-161));

  assign w_bmrClamped = w_bmr[BW-1]            ? '0 :
                        (|w_bmr[BW-2:DATA_W])  ? '1 :
                                                 w_bmr[DATA_W-1:0];

  always_comb begin
    w_factor = 11'd0;
    case (r_activity)
      3'd0:    w_factor = 11'd1200;
      3'd1:    w_factor = 11'd1375;
      3'd2:    w_factor = 11'd1550;
      3'd3:    w_factor = 11'd1725;
      3'd4:    w_factor = 11'd1900;
      default: w_factor = 11'd0;
    endcase
  end

  always_comb begin
    w_dividend = '0;
    w_divisor  = '0;
    if (r_op == OP_BMI) begin
      w_dividend = (W2'(r_weight) * W2'(10000)) << FRAC_W;
      w_divisor  = W2'(r_height) * W2'(r_height);
    end else begin
      w_dividend = W2'(w_bmrClamped) * W2'(w_factor);
      w_divisor  = W2'(1000);
    end
  end

  // Quotient would need more than DATA_W bits: run the divider anyway, saturate at the end.
  assign w_ovf = W3'(w_dividend) >= (W3'(w_divisor) << DATA_W);
  assign w_ge  = W3'(r_rem) >= r_dvs;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid && in_ready) w_nextState = PREP;
      PREP:    w_nextState = (!w_err && w_divOp) ? DIV : DONE;
      DIV:     if (r_cnt == CW'(DATA_W - 1)) w_nextState = DONE;
      DONE:    if (r_outValid && out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_readyEn  <= 1'b0;
      r_op       <= '0;
      r_height   <= '0;
      r_weight   <= '0;
      r_age      <= '0;
      r_gender   <= 1'b0;
      r_activity <= '0;
      r_err      <= 1'b0;
      r_sat      <= 1'b0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_errOut   <= 1'b0;
      r_result   <= '0;
    end else begin
      r_readyEn <= 1'b1;
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_op       <= op;
            r_height   <= height;
            r_weight   <= weight;
            r_age      <= age;
            r_gender   <= gender;
            r_activity <= activity;
          end
        end
        PREP: begin
          r_err  <= w_err;
          r_sat  <= !w_err && w_divOp && w_ovf;
          r_cnt  <= '0;
          r_quot <= (w_err || w_divOp) ? '0 : w_bmrClamped;
          r_rem  <= (!w_err && w_divOp) ? w_dividend : '0;
          r_dvs  <= (!w_err && w_divOp) ? (W3'(w_divisor) << (DATA_W - 1)) : '0;
        end
        DIV: begin
          if (w_ge) r_rem <= r_rem - r_dvs[W2-1:0];
          r_quot <= {r_quot[DATA_W-2:0], w_ge};
          r_dvs  <= r_dvs >> 1;
          r_cnt  <= r_cnt + CW'(1);
        end
        DONE: begin
          // First DONE cycle registers the final result; it then holds until accepted.
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_errOut   <= r_err;
            r_result   <= r_err ? '0 : (r_sat ? '1 : r_quot);
          end else if (out_ready) begin
            r_outValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_health_calc_unit.sv
// Self-checking bench for health_calc_unit: fixed vectors, randomized requests
// against an arithmetic reference model, backpressure and mid-divide reset.
module tb_health_calc_unit;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = '0;
  logic [31:0] height = '0;
  logic [31:0] weight = '0;
  logic [5:0]  age = '0;
  logic        gender = 1'b0;
  logic [2:0]  activity = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        err;

  int nChecks = 0;
  int nFail = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] h;
    logic [31:0] w;
    logic [5:0]  age;
    logic        g;
    logic [2:0]  act;
    logic [31:0] expRes;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  health_calc_unit #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .height(height), .weight(weight), .age(age), .gender(gender),
    .activity(activity), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built directly from the arithmetic definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] h, input logic [31:0] w,
                                input logic [5:0] a, input logic g, input logic [2:0] act,
                                output logic [31:0] res, output logic e, output int lat);
    longint            b;
    longint unsigned   bmr, q;
    longint unsigned   factors [5] = '{1200, 1375, 1550, 1725, 1900};
    res = '0;
    e   = 1'b0;
    lat = 2;
    b = 10 * longint'(w) + (25 * longint'(h)) / 4 - 5 * longint'(a) + (g ? 5 : -161);
    if (b < 0)                    bmr = 0;
    else if (b > 64'sd4294967295) bmr = 64'hFFFF_FFFF;
    else                          bmr = longint'(b);
    case (o)
      2'b00: begin
        if (h == 0) e = 1'b1;
        else begin
          q = (longint'(w) * 10000 * (64'd1 << FRAC_W)) / (longint'(h) * longint'(h));
          res = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
          lat = 34;
        end
      end
      2'b01: res = bmr[31:0];
      2'b10: begin
        if (act > 4) e = 1'b1;
        else begin
          q = (bmr * factors[act]) / 1000;
          res = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
          lat = 34;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic startRequest(input logic [1:0] o, input logic [31:0] h, input logic [31:0] w,
                              input logic [5:0] a, input logic g, input logic [2:0] act);
    int n = 0;
    op = o; height = h; weight = w; age = a; gender = g; activity = act;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkVal("in_ready_for_request", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); height = $urandom; weight = $urandom;
    age = 6'($urandom); gender = 1'($urandom); activity = 3'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] h, input logic [31:0] w,
                               input logic [5:0] a, input logic g, input logic [2:0] act,
                               output logic [31:0] res, output logic e, output int lat);
    startRequest(o, h, w, a, g, act);
    waitResult(lat);
    res = result;
    e   = err;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] res, input logic e, input int lat,
                             input logic [31:0] expRes, input logic expErr, input int expLat);
    checkVal({name, "_result"}, res, expRes);
    checkVal({name, "_err"}, e, expErr);
    checkVal({name, "_latency"}, lat, expLat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({name, "_released"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] res, expRes, h, w;
    logic        e, expErr;
    int          lat, expLat, stray;
    logic [1:0]  o;
    logic [5:0]  a;
    logic        g;
    logic [2:0]  act;

    vecs.push_back(vec_t'{"bmi_basic",    2'd0, 32'd175, 32'd70, 6'd0,  1'b0, 3'd0, 32'd5851, 1'b0, 34});
    vecs.push_back(vec_t'{"bmr_male",     2'd1, 32'd175, 32'd70, 6'd30, 1'b1, 3'd0, 32'd1648, 1'b0, 2});
    vecs.push_back(vec_t'{"bmr_female",   2'd1, 32'd175, 32'd70, 6'd30, 1'b0, 3'd0, 32'd1482, 1'b0, 2});
    vecs.push_back(vec_t'{"bmr_negative", 2'd1, 32'd0,   32'd0,  6'd63, 1'b0, 3'd0, 32'd0,    1'b0, 2});
    vecs.push_back(vec_t'{"bmr_saturate", 2'd1, 32'd0,   32'hFFFF_FFFF, 6'd0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 2});
    vecs.push_back(vec_t'{"tdee_act2",    2'd2, 32'd175, 32'd70, 6'd30, 1'b1, 3'd2, 32'd2554, 1'b0, 34});
    vecs.push_back(vec_t'{"tdee_act5",    2'd2, 32'd175, 32'd70, 6'd30, 1'b1, 3'd5, 32'd0,    1'b1, 2});
    vecs.push_back(vec_t'{"bmi_h0",       2'd0, 32'd0,   32'd70, 6'd30, 1'b1, 3'd0, 32'd0,    1'b1, 2});
    vecs.push_back(vec_t'{"op_reserved",  2'd3, 32'd175, 32'd70, 6'd30, 1'b1, 3'd0, 32'd0,    1'b1, 2});
    vecs.push_back(vec_t'{"bmi_saturate", 2'd0, 32'd1,   32'hFFFF_FFFF, 6'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 34});

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_in_ready", in_ready, 0);
    checkVal("reset_out_valid", out_valid, 0);
    checkVal("reset_result", result, 0);
    checkVal("reset_err", err, 0);
    rst_n = 1'b1;
    #1;
    checkVal("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk); #1;
    checkVal("in_ready_after_release", in_ready, 1);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].h, vecs[i].w, vecs[i].age, vecs[i].g, vecs[i].act, res, e, lat);
      checkOutput(vecs[i].name, res, e, lat, vecs[i].expRes, vecs[i].expErr, vecs[i].expLat);
    end

    $display("[TB] randomized requests");
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      h   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 250);
      w   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 200);
      a   = 6'($urandom_range(0, 63));
      g   = 1'($urandom_range(0, 1));
      act = 3'($urandom_range(0, 7));
      model(o, h, w, a, g, act, expRes, expErr, expLat);
      applyStimulus(o, h, w, a, g, act, res, e, lat);
      checkOutput($sformatf("rand%0d", i), res, e, lat, expRes, expErr, expLat);
    end

    $display("[TB] backpressure");
    startRequest(2'd0, 32'd175, 32'd70, 6'd0, 1'b0, 3'd0);
    waitResult(lat);
    checkVal("bp_latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op = 2'd1; height = 32'd100; weight = 32'd50;
      @(posedge clk); #1;
      checkVal("bp_result", result, 5851);
      checkVal("bp_err", err, 0);
      checkVal("bp_in_ready", in_ready, 0);
      checkVal("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("bp_in_ready_after_transfer", in_ready, 1);
    checkVal("bp_out_valid_after_transfer", out_valid, 0);
    applyStimulus(2'd1, 32'd175, 32'd70, 6'd30, 1'b1, 3'd0, res, e, lat);
    checkOutput("bp_next", res, e, lat, 32'd1648, 1'b0, 2);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checkVal("bp_no_stray_response", stray, 0);

    $display("[TB] reset during divide");
    startRequest(2'd0, 32'd175, 32'd70, 6'd0, 1'b0, 3'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkVal("midreset_in_ready", in_ready, 0);
    checkVal("midreset_out_valid", out_valid, 0);
    checkVal("midreset_result", result, 0);
    checkVal("midreset_err", err, 0);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checkVal("midreset_no_stale_valid", stray, 0);
    applyStimulus(2'd0, 32'd175, 32'd70, 6'd0, 1'b0, 3'd0, res, e, lat);
    checkOutput("post_reset_bmi", res, e, lat, 32'd5851, 1'b0, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
